// File: rtl/rvv_fifo_pkg.sv
// rvv_fifo_pkg: shared width helper and status bundle for the RVV flopped FIFOs
package rvv_fifo_pkg;
  localparam int STATUS_CW = 16;
  typedef struct packed {
    logic [STATUS_CW-1:0] count;
    logic                 full;
    logic                 empty;
    logic                 afull;
  } fifo_status_t;
  function automatic int clogb2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r = r + 1;
    return r;
  endfunction
endpackage

// File: rtl/fifo_ptr_add.sv
// fifo_ptr_add: pointer plus increment, wrapped modulo DEPTH (increment never exceeds DEPTH)
module fifo_ptr_add #(
  parameter int DEPTH  = 16,
  parameter int AWIDTH = 4,
  parameter int NWIDTH = 5
) (
  input  logic [AWIDTH-1:0] ptr,
  input  logic [NWIDTH-1:0] n,
  output logic [AWIDTH-1:0] sum
);
  localparam int SW = AWIDTH + 1;
  logic [SW-1:0] s;
  assign s   = {1'b0, ptr} + SW'(n);
  assign sum = (s >= SW'(DEPTH)) ? AWIDTH'(s - SW'(DEPTH)) : AWIDTH'(s);
endmodule

// File: rtl/fifo_flopped_multiport.sv
// fifo_flopped_multiport: flop-based in-order FIFO with several push and pop lanes per cycle
module fifo_flopped_multiport
  import rvv_fifo_pkg::*;
#(
  parameter int DWIDTH   = 32,
  parameter int DEPTH    = 16,
  parameter int PUSH_NUM = 2,
  parameter int POP_NUM  = 2,
  parameter int AFULL_TH = 14,
  localparam int AWIDTH  = (DEPTH == 1) ? 1 : clogb2(DEPTH),
  localparam int CWIDTH  = clogb2(DEPTH + 1)
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         clear,
  input  logic [PUSH_NUM-1:0]          push,
  input  logic [PUSH_NUM*DWIDTH-1:0]   push_data,
  output logic [PUSH_NUM-1:0]          push_ready,
  input  logic [POP_NUM-1:0]           pop,
  output logic [POP_NUM*DWIDTH-1:0]    pop_data,
  output logic [POP_NUM-1:0]           pop_valid,
  output logic [CWIDTH-1:0]            fifo_count,
  output logic                         fifo_full,
  output logic                         fifo_empty,
  output logic                         fifo_almost_full,
  output logic                         fifo_idle
);
  logic [DWIDTH-1:0] mem [DEPTH];
  logic [DWIDTH-1:0] wd [DEPTH];
  logic [DEPTH-1:0]  we;
  logic [AWIDTH-1:0] wr_ptr, rd_ptr, wr_nxt, rd_nxt;
  logic [AWIDTH-1:0] waddr [PUSH_NUM];
  logic [AWIDTH-1:0] raddr [POP_NUM];
  logic [CWIDTH-1:0] cnt, npush, npop;
  fifo_status_t      st;
  always_comb begin
    npush = '0;
    npop  = '0;
    for (int i = 0; i < PUSH_NUM; i++) npush = npush + CWIDTH'(push[i]);
    for (int j = 0; j < POP_NUM; j++) npop = npop + CWIDTH'(pop[j]);
  end
  fifo_ptr_add #(.DEPTH(DEPTH), .AWIDTH(AWIDTH), .NWIDTH(CWIDTH)) u_wr_nxt (.ptr(wr_ptr), .n(npush), .sum(wr_nxt));
  fifo_ptr_add #(.DEPTH(DEPTH), .AWIDTH(AWIDTH), .NWIDTH(CWIDTH)) u_rd_nxt (.ptr(rd_ptr), .n(npop), .sum(rd_nxt));
  for (genvar i = 0; i < PUSH_NUM; i++) begin : g_push
    fifo_ptr_add #(.DEPTH(DEPTH), .AWIDTH(AWIDTH), .NWIDTH(CWIDTH)) u_waddr (.ptr(wr_ptr), .n(CWIDTH'(i)), .sum(waddr[i]));
    assign push_ready[i] = (CWIDTH'(DEPTH) - cnt) > CWIDTH'(i);
  end
  for (genvar j = 0; j < POP_NUM; j++) begin : g_pop
    fifo_ptr_add #(.DEPTH(DEPTH), .AWIDTH(AWIDTH), .NWIDTH(CWIDTH)) u_raddr (.ptr(rd_ptr), .n(CWIDTH'(j)), .sum(raddr[j]));
    assign pop_valid[j] = cnt > CWIDTH'(j);
    assign pop_data[j*DWIDTH +: DWIDTH] = mem[raddr[j]];
  end
  // lanes target distinct entries, so at most one lane claims each entry
  always_comb begin
    for (int e = 0; e < DEPTH; e++) begin
      we[e] = 1'b0;
      wd[e] = '0;
      for (int i = 0; i < PUSH_NUM; i++)
        if (!clear && push[i] && waddr[i] == AWIDTH'(e)) begin
          we[e] = 1'b1;
          wd[e] = push_data[i*DWIDTH +: DWIDTH];
        end
    end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) for (int e = 0; e < DEPTH; e++) mem[e] <= '0;
    else for (int e = 0; e < DEPTH; e++) if (we[e]) mem[e] <= wd[e];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (|push) wr_ptr <= wr_nxt;
      if (|pop) rd_ptr <= rd_nxt;
      if (|push || |pop) cnt <= cnt + npush - npop;
    end
  assign st.count = STATUS_CW'(cnt);
  assign st.full  = int'(cnt) == DEPTH;
  assign st.empty = cnt == '0;
  assign st.afull = int'(cnt) >= AFULL_TH;
  assign fifo_count       = CWIDTH'(st.count);
  assign fifo_full        = st.full;
  assign fifo_empty       = st.empty;
  assign fifo_almost_full = st.afull;
  assign fifo_idle        = st.empty;
`ifdef ASSERT_ON
  always_ff @(posedge clk)
    if (rst_n) begin
      assert (!(|(push & ~push_ready)));
      assert (!(|(pop & ~pop_valid)));
      assert ((PUSH_NUM'(push + 1'b1) & push) == '0);
      assert ((POP_NUM'(pop + 1'b1) & pop) == '0);
    end
`endif
endmodule

// File: tb/tb_fifo_flopped_multiport.sv
// tb_fifo_flopped_multiport: directed scoreboard bench for the two-lane FIFO, DEPTH=6
module tb_fifo_flopped_multiport;
  logic        clk = 0, rst_n = 0, clear = 0;
  logic [1:0]  push = 0, pop = 0;
  logic [15:0] push_data = 0;
  logic [1:0]  push_ready, pop_valid;
  logic [15:0] pop_data;
  logic [2:0]  fifo_count;
  logic        fifo_full, fifo_empty, fifo_almost_full, fifo_idle;
  int          total = 0, bad = 0;
  logic [7:0]  q[$];

  fifo_flopped_multiport #(.DWIDTH(8), .DEPTH(6), .PUSH_NUM(2), .POP_NUM(2), .AFULL_TH(5)) dut (
    .clk(clk), .rst_n(rst_n), .clear(clear), .push(push), .push_data(push_data),
    .push_ready(push_ready), .pop(pop), .pop_data(pop_data), .pop_valid(pop_valid),
    .fifo_count(fifo_count), .fifo_full(fifo_full), .fifo_empty(fifo_empty),
    .fifo_almost_full(fifo_almost_full), .fifo_idle(fifo_idle));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic status();
    int n;
    n = q.size();
    chk("count", 32'(fifo_count), n);
    chk("full", fifo_full, n == 6);
    chk("empty", fifo_empty, n == 0);
    chk("idle", fifo_idle, n == 0);
    chk("afull", fifo_almost_full, n >= 5);
    chk("pop_valid", pop_valid, {n > 1, n > 0});
    chk("push_ready", push_ready, {(6 - n) > 1, (6 - n) > 0});
    for (int j = 0; j < 2; j++) if (j < n) chk("pop_data", pop_data[j*8 +: 8], q[j]);
  endtask

  task automatic cyc(input logic [1:0] pu, input logic [7:0] d0, input logic [7:0] d1,
                     input logic [1:0] po, input logic cl);
    push = pu;
    push_data = {d1, d0};
    pop = po;
    clear = cl;
    @(negedge clk);
    status();
    @(posedge clk);
    #1;
    if (cl) q.delete();
    else begin
      for (int j = 0; j < 2; j++) if (po[j]) void'(q.pop_front());
      if (pu[0]) q.push_back(d0);
      if (pu[1]) q.push_back(d1);
    end
    push = 0;
    pop = 0;
    clear = 0;
  endtask

  initial begin
    @(negedge clk);
    status();
    chk("reset_pop_data", pop_data, 16'h0);
    @(posedge clk);
    #1 rst_n = 1;
    cyc(2'b11, 8'hA0, 8'hA1, 2'b00, 0);
    cyc(2'b11, 8'hA2, 8'hA3, 2'b00, 0);
    cyc(2'b00, 8'h00, 8'h00, 2'b11, 0);
    cyc(2'b11, 8'hB0, 8'hB1, 2'b00, 0);
    cyc(2'b01, 8'hB2, 8'h00, 2'b00, 0);
    cyc(2'b01, 8'hB3, 8'h00, 2'b00, 0);
    cyc(2'b00, 8'h00, 8'h00, 2'b11, 0);
    for (int k = 0; k < 20; k++) cyc(2'b11, 8'(2 * k), 8'(2 * k + 1), 2'b11, 0);
    cyc(2'b01, 8'hC0, 8'h00, 2'b00, 0);
    cyc(2'b01, 8'hC1, 8'h00, 2'b01, 0);
    cyc(2'b01, 8'hC2, 8'h00, 2'b00, 0);
    cyc(2'b00, 8'h00, 8'h00, 2'b11, 0);
    cyc(2'b11, 8'hD0, 8'hD1, 2'b00, 1);
    cyc(2'b11, 8'hE0, 8'hE1, 2'b00, 0);
    cyc(2'b01, 8'hE2, 8'h00, 2'b01, 0);
    @(negedge clk);
    status();
    @(posedge clk);
    #1 rst_n = 0;
    #1;
    q.delete();
    status();
    chk("rst_pop_data", pop_data, 16'h0);
    @(posedge clk);
    #1 rst_n = 1;
    cyc(2'b00, 8'h00, 8'h00, 2'b00, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
